// File: rtl/pipeline_pkg.sv
// Shared pipeline types: ALUOp encoding, EX-stage control bundle and register-index width.
package pipeline_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    ALUOP_MEM    = 2'b00,  // LW / SW / AUIPC
    ALUOP_BRANCH = 2'b01,
    ALUOP_ARITH  = 2'b10,  // R / I-type
    ALUOP_JUMP   = 2'b11   // JAL / LUI
  } alu_op_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
    logic branch;
  } ex_ctrl_t;

  localparam ex_ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination feeds the instruction in ID.
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic                 i_ex_valid,
  input  logic                 i_ex_mem_read,
  input  logic [REG_IDX_W-1:0] i_ex_rd,
  input  logic                 i_id_valid,
  input  logic [REG_IDX_W-1:0] i_id_rs1,
  input  logic [REG_IDX_W-1:0] i_id_rs2,
  output logic                 o_load_use
);

  logic w_rd_nonzero;
  logic w_rd_match;

  // x0 is hard-wired zero, so a load targeting it never creates a real dependency.
  assign w_rd_nonzero = (i_ex_rd != '0);
  assign w_rd_match   = (i_ex_rd == i_id_rs1) || (i_ex_rd == i_id_rs2);
  assign o_load_use   = i_ex_valid && i_ex_mem_read && i_id_valid && w_rd_nonzero && w_rd_match;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with flush, hold and single-cycle load-use bubble insertion.
module id_ex_reg
  import pipeline_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [1:0]           id_ALUOp,
  input  logic [2:0]           id_Funct3,
  input  logic [6:0]           id_Funct7,
  input  logic                 id_RegWrite,
  input  logic                 id_MemRead,
  input  logic                 id_MemWrite,
  input  logic                 id_MemtoReg,
  input  logic                 id_ALUSrc,
  input  logic                 id_Branch,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic [DATA_W-1:0]    id_rd1,
  input  logic [DATA_W-1:0]    id_rd2,
  input  logic [DATA_W-1:0]    id_imm,
  input  logic [DATA_W-1:0]    id_pc,
  input  logic                 hold,
  input  logic                 flush,
  output logic                 ex_valid,
  output logic [1:0]           ex_ALUOp,
  output logic [2:0]           ex_Funct3,
  output logic [6:0]           ex_Funct7,
  output logic                 ex_RegWrite,
  output logic                 ex_MemRead,
  output logic                 ex_MemWrite,
  output logic                 ex_MemtoReg,
  output logic                 ex_ALUSrc,
  output logic                 ex_Branch,
  output logic [REG_IDX_W-1:0] ex_rs1,
  output logic [REG_IDX_W-1:0] ex_rs2,
  output logic [REG_IDX_W-1:0] ex_rd,
  output logic [DATA_W-1:0]    ex_rd1,
  output logic [DATA_W-1:0]    ex_rd2,
  output logic [DATA_W-1:0]    ex_imm,
  output logic [DATA_W-1:0]    ex_pc,
  output logic                 stall_ifid,
  output logic [CNT_W-1:0]     bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic                 r_valid;
  alu_op_e              r_alu_op;
  ex_ctrl_t             r_ctrl;
  logic [2:0]           r_funct3;
  logic [6:0]           r_funct7;
  logic [REG_IDX_W-1:0] r_rs1, r_rs2, r_rd;
  logic [DATA_W-1:0]    r_rd1, r_rd2, r_imm, r_pc;
  logic [CNT_W-1:0]     r_bubble_cnt;

  ex_ctrl_t w_id_ctrl;
  logic     w_load_use;

  assign w_id_ctrl = '{reg_write:  id_RegWrite, mem_read: id_MemRead, mem_write: id_MemWrite,
                       mem_to_reg: id_MemtoReg, alu_src:  id_ALUSrc,  branch:    id_Branch};

  hazard_detect u_hazard_detect (
    .i_ex_valid    (r_valid),
    .i_ex_mem_read (r_ctrl.mem_read),
    .i_ex_rd       (r_rd),
    .i_id_valid    (id_valid),
    .i_id_rs1      (id_rs1),
    .i_id_rs2      (id_rs2),
    .o_load_use    (w_load_use)
  );

  // Reset masks the request so the front end never sees a stall while the pipe is being cleared.
  assign stall_ifid = w_load_use && !flush && !reset;

  // NOTE: every register below is assigned with <= so all fields sample pre-edge values together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_alu_op     <= ALUOP_MEM;
      r_ctrl       <= CTRL_NOP;
      r_funct3     <= '0;
      r_funct7     <= '0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_rd         <= '0;
      r_rd1        <= '0;
      r_rd2        <= '0;
      r_imm        <= '0;
      r_pc         <= '0;
      r_bubble_cnt <= '0;
    end else if (flush) begin
      r_valid  <= 1'b0;
      r_alu_op <= ALUOP_MEM;
      r_ctrl   <= CTRL_NOP;
    end else if (!hold) begin
      if (w_load_use) begin
        // Bubble: only the fields that make EX act are cleared; operands are left as-is.
        r_valid      <= 1'b0;
        r_alu_op     <= ALUOP_MEM;
        r_ctrl       <= CTRL_NOP;
        r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
      end else begin
        r_valid  <= id_valid;
        r_alu_op <= id_valid ? alu_op_e'(id_ALUOp) : ALUOP_MEM;
        r_ctrl   <= id_valid ? w_id_ctrl : CTRL_NOP;
        r_funct3 <= id_Funct3;
        r_funct7 <= id_Funct7;
        r_rs1    <= id_rs1;
        r_rs2    <= id_rs2;
        r_rd     <= id_rd;
        r_rd1    <= id_rd1;
        r_rd2    <= id_rd2;
        r_imm    <= id_imm;
        r_pc     <= id_pc;
      end
    end
  end

  assign ex_valid    = r_valid;
  assign ex_ALUOp    = r_alu_op;
  assign ex_Funct3   = r_funct3;
  assign ex_Funct7   = r_funct7;
  assign ex_RegWrite = r_ctrl.reg_write;
  assign ex_MemRead  = r_ctrl.mem_read;
  assign ex_MemWrite = r_ctrl.mem_write;
  assign ex_MemtoReg = r_ctrl.mem_to_reg;
  assign ex_ALUSrc   = r_ctrl.alu_src;
  assign ex_Branch   = r_ctrl.branch;
  assign ex_rs1      = r_rs1;
  assign ex_rs2      = r_rs2;
  assign ex_rd       = r_rd;
  assign ex_rd1      = r_rd1;
  assign ex_rd2      = r_rd2;
  assign ex_imm      = r_imm;
  assign ex_pc       = r_pc;
  assign bubble_cnt  = r_bubble_cnt;

endmodule
